// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32I instruction encoder, two-stage valid/ready pipeline with IMEM word addressing
// Optional range/alignment checking of immediates: define INSTR_ENC_RANGE_CHK_EN.
`timescale 1ns/1ps
module instr_encoder #(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(32'h0000_0000),
    parameter int                DEPTH_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    input  logic              addr_clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err
);

    localparam int          IW  = (DEPTH_WORDS > 2) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef INSTR_ENC_RANGE_CHK_EN
    localparam bit RANGE_CHK = 1'b1;
`else
    localparam bit RANGE_CHK = 1'b0;
`endif

    logic        s1_valid;
    logic [2:0]  s1_fmt;
    logic [6:0]  s1_opcode;
    logic [4:0]  s1_rd;
    logic [4:0]  s1_rs1;
    logic [4:0]  s1_rs2;
    logic [2:0]  s1_funct3;
    logic [6:0]  s1_funct7;
    logic [31:0] s1_imm;

    logic        s2_valid;
    logic [31:0] s2_instr;
    logic        s2_err;
    logic [IW-1:0] idx;

    logic        s2_free;
    logic [31:0] enc_instr;
    logic        enc_err;
    logic        range_ok;
    logic        fits12;
    logic        fits13;
    logic        fits21;

    assign s2_free  = !s2_valid || out_ready;
    assign in_ready = !s1_valid || s2_free;

    // A signed value fits in N bits when everything from bit N-1 upward is pure sign extension
    assign fits12 = (&s1_imm[31:11]) | ~(|s1_imm[31:11]);
    assign fits13 = (&s1_imm[31:12]) | ~(|s1_imm[31:12]);
    assign fits21 = (&s1_imm[31:20]) | ~(|s1_imm[31:20]);

    always_comb begin
        enc_instr = NOP;
        enc_err   = 1'b0;
        range_ok  = 1'b1;
        case (s1_fmt)
            3'd0: enc_instr = {s1_funct7, s1_rs2, s1_rs1, s1_funct3, s1_rd, s1_opcode};
            3'd1: begin
                enc_instr = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
                range_ok  = fits12;
            end
            3'd2: begin
                enc_instr = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3, s1_imm[4:0], s1_opcode};
                range_ok  = fits12;
            end
            3'd3: begin
                enc_instr = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3,
                             s1_imm[4:1], s1_imm[11], s1_opcode};
                range_ok  = fits13 & ~s1_imm[0];
            end
            3'd4: begin
                enc_instr = {s1_imm[31:12], s1_rd, s1_opcode};
                range_ok  = ~(|s1_imm[11:0]);
            end
            3'd5: begin
                enc_instr = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd, s1_opcode};
                range_ok  = fits21 & ~s1_imm[0];
            end
            default: enc_err = 1'b1;
        endcase
        if (RANGE_CHK && !range_ok) begin
            enc_instr = NOP;
            enc_err   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_fmt    <= '0;
            s1_opcode <= '0;
            s1_rd     <= '0;
            s1_rs1    <= '0;
            s1_rs2    <= '0;
            s1_funct3 <= '0;
            s1_funct7 <= '0;
            s1_imm    <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_fmt    <= in_fmt;
                s1_opcode <= in_opcode;
                s1_rd     <= in_rd;
                s1_rs1    <= in_rs1;
                s1_rs2    <= in_rs2;
                s1_funct3 <= in_funct3;
                s1_funct7 <= in_funct7;
                s1_imm    <= in_imm;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_instr <= '0;
            s2_err   <= 1'b0;
        end else if (s2_free) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_instr <= enc_instr;
                s2_err   <= enc_err;
            end
        end
    end

    // Clear takes priority so a word handshaking alongside addr_clr keeps its old address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (addr_clr) begin
            idx <= '0;
        end else if (out_valid && out_ready) begin
            idx <= idx + 1'b1;
        end
    end

    assign out_valid = s2_valid;
    assign out_instr = s2_instr;
    assign out_err   = s2_err;
    assign out_addr  = BASE_ADDR + (ADDR_W'(idx) << 2);

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - scoreboard bench for instr_encoder
`timescale 1ns/1ps
module tb_instr_encoder;

    localparam int          ADDR_W = 32;
    localparam logic [31:0] BASE   = 32'h0000_0100;
    localparam int          DEPTH  = 4;
`ifdef INSTR_ENC_RANGE_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_fmt = '0;
    logic [6:0]  in_opcode = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [31:0] in_imm = '0;
    logic        addr_clr = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        out_err;

    instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .addr_clr(addr_clr), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_instr = '0;
    logic        exp_err = 1'b0;
    int          exp_idx = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          acc_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Reference encoder built from shifts and masks; returns {err, instr}
    function automatic logic [32:0] ref_enc(input logic [2:0] fmt, input logic [6:0] op,
                                            input logic [4:0] rd, input logic [4:0] rs1,
                                            input logic [4:0] rs2, input logic [2:0] f3,
                                            input logic [6:0] f7, input logic [31:0] i);
        logic [31:0] w, d, a, b, f;
        int s;
        bit bad, illegal;
        d = 32'(rd) << 7;  a = 32'(rs1) << 15;  b = 32'(rs2) << 20;  f = 32'(f3) << 12;
        s = $signed(i);
        bad = 1'b0;  illegal = 1'b0;  w = '0;
        case (fmt)
            3'd0: w = (32'(f7) << 25) | b | a | f | d | 32'(op);
            3'd1: begin
                w = ((i & 32'hFFF) << 20) | a | f | d | 32'(op);
                bad = (s < -2048) || (s > 2047);
            end
            3'd2: begin
                w = (((i >> 5) & 32'h7F) << 25) | b | a | f | ((i & 32'h1F) << 7) | 32'(op);
                bad = (s < -2048) || (s > 2047);
            end
            3'd3: begin
                w = (((i >> 12) & 32'h1) << 31) | (((i >> 5) & 32'h3F) << 25) | b | a | f
                  | (((i >> 1) & 32'hF) << 8) | (((i >> 11) & 32'h1) << 7) | 32'(op);
                bad = (s < -4096) || (s > 4094) || ((i & 32'h1) != 0);
            end
            3'd4: begin
                w = (i & 32'hFFFF_F000) | d | 32'(op);
                bad = (i & 32'hFFF) != 0;
            end
            3'd5: begin
                w = (((i >> 20) & 32'h1) << 31) | (((i >> 1) & 32'h3FF) << 21)
                  | (((i >> 11) & 32'h1) << 20) | (((i >> 12) & 32'hFF) << 12) | d | 32'(op);
                bad = (s < -1048576) || (s > 1048574) || ((i & 32'h1) != 0);
            end
            default: illegal = 1'b1;
        endcase
        if (CHK && bad) illegal = 1'b1;
        return illegal ? {1'b1, 32'h0000_0013} : {1'b0, w};
    endfunction

    task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm,
                        input logic [31:0] ei, input logic ee);
        logic acc;
        in_fmt = fmt;  in_opcode = op;  in_rd = rd;  in_rs1 = rs1;  in_rs2 = rs2;
        in_funct3 = f3;  in_funct7 = f7;  in_imm = imm;
        exp_instr = ei;  exp_err = ee;
        in_valid = 1'b1;
        acc = 1'b0;
        for (int t = 0; t < 60 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
        check_val("accept", 32'(acc), 32'h1);
        if (acc) acc_cnt++;
    endtask

    task automatic send_m(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [31:0] imm);
        logic [32:0] r;
        r = ref_enc(fmt, op, rd, rs1, rs2, f3, f7, imm);
        send(fmt, op, rd, rs1, rs2, f3, f7, imm, r[31:0], r[32]);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int c = 0; c < 200 && sb.size() != 0; c++) @(negedge clk);
        check_val("drain", 32'(sb.size()), 32'h0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare the head of the scoreboard every cycle a word is presented, push on accepts
    initial begin
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                sb.delete();
                exp_idx = 0;
            end else begin
                if (out_valid) begin
                    if (sb.size() == 0) begin
                        check_val("spurious_word", 32'(out_valid), 32'h0);
                    end else begin
                        check_val("instr", out_instr, sb[0].instr);
                        check_val("err", 32'(out_err), 32'(sb[0].err));
                        check_val("addr", out_addr, BASE + 32'(4 * exp_idx));
                    end
                end
                if (addr_clr) exp_idx = 0;
                else if (out_valid && out_ready) exp_idx = (exp_idx + 1) % DEPTH;
                if (out_valid && out_ready && sb.size() != 0) void'(sb.pop_front());
                if (in_valid && in_ready) sb.push_back('{exp_instr, exp_err});
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_out_valid", 32'(out_valid), 32'h0);
        check_val("rst_out_instr", out_instr, 32'h0);
        check_val("rst_out_addr", out_addr, BASE);
        check_val("rst_out_err", 32'(out_err), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_in_ready", 32'(in_ready), 32'h1);
        @(posedge clk);
        #1;

        // single request and latency
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0093, 1'b0);
        @(negedge clk);
        check_val("lat_cycle1", 32'(out_valid), 32'h0);
        @(negedge clk);
        check_val("lat_cycle2", 32'(out_valid), 32'h1);
        @(posedge clk);
        #1;

        // back-to-back from address 0
        addr_clr = 1'b1;
        @(posedge clk);
        #1;
        addr_clr = 1'b0;
        send(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 32'h0020_A423, 1'b0);
        send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0);
        send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h0010_00EF, 1'b0);
        send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
        @(negedge clk);
        check_val("b2b_valid_a", 32'(out_valid), 32'h1);
        @(negedge clk);
        check_val("b2b_valid_b", 32'(out_valid), 32'h1);
        @(posedge clk);
        #1;
        drain();

        // range errors and illegal format
        if (CHK) begin
            send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096, 32'h0000_0013, 1'b1);
            send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h0000_0013, 1'b1);
        end else begin
            send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096, 32'h0000_0093, 1'b0);
            send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h0000_0163, 1'b0);
        end
        send(3'd7, 7'h13, 5'd3, 5'd4, 5'd5, 3'd1, 7'd0, 32'd0, 32'h0000_0013, 1'b1);
        send(3'd6, 7'h33, 5'd3, 5'd4, 5'd5, 3'd1, 7'd0, 32'd0, 32'h0000_0013, 1'b1);

        // immediate boundaries on each side of every range
        send_m(3'd1, 7'h13, 5'd2, 5'd3, 5'd0, 3'd0, 7'd0, 32'd2047);
        send_m(3'd1, 7'h13, 5'd2, 5'd3, 5'd0, 3'd0, 7'd0, -32'sd2048);
        send_m(3'd1, 7'h13, 5'd2, 5'd3, 5'd0, 3'd0, 7'd0, 32'd2048);
        send_m(3'd2, 7'h23, 5'd0, 5'd3, 5'd4, 3'd2, 7'd0, -32'sd2049);
        send_m(3'd2, 7'h23, 5'd0, 5'd3, 5'd4, 3'd2, 7'd0, 32'd2047);
        send_m(3'd3, 7'h63, 5'd0, 5'd6, 5'd7, 3'd1, 7'd0, 32'd4094);
        send_m(3'd3, 7'h63, 5'd0, 5'd6, 5'd7, 3'd1, 7'd0, -32'sd4096);
        send_m(3'd3, 7'h63, 5'd0, 5'd6, 5'd7, 3'd1, 7'd0, 32'd4096);
        send_m(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1048574);
        send_m(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd1048576);
        send_m(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1048576);
        send_m(3'd4, 7'h17, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1234);
        drain();

        // backpressure: two held, then in_ready low
        out_ready = 1'b0;
        acc_cnt = 0;
        fork
            begin
                for (int k = 0; k < 6; k++)
                    send_m(3'd0, 7'h33, 5'(k + 1), 5'(k + 7), 5'(k + 13), 3'(k), 7'(k * 3), 32'd0);
            end
            begin
                for (int c = 0; c < 40 && acc_cnt < 2; c++) @(posedge clk);
                @(negedge clk);
                check_val("bp_in_ready", 32'(in_ready), 32'h0);
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // random traffic with random consumer stalls
        fork
            begin
                for (int k = 0; k < 24; k++) begin
                    logic [31:0] imm;
                    case ($urandom_range(0, 3))
                        0: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                        1: imm = $urandom;
                        2: imm = $urandom & 32'h001F_FFFE;
                        default: imm = $urandom & 32'hFFFF_F000;
                    endcase
                    send_m(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom),
                           5'($urandom), 3'($urandom), 7'($urandom), imm);
                end
            end
            begin
                for (int c = 0; c < 60; c++) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // address wrap, then clear coinciding with a handshake
        addr_clr = 1'b1;
        @(posedge clk);
        #1;
        addr_clr = 1'b0;
        for (int k = 0; k < 5; k++)
            send_m(3'd1, 7'h13, 5'(k), 5'(k), 5'd0, 3'd0, 7'd0, 32'(k * 4));
        drain();
        out_ready = 1'b0;
        send_m(3'd1, 7'h13, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'd100);
        send_m(3'd1, 7'h13, 5'd11, 5'd0, 5'd0, 3'd0, 7'd0, 32'd200);
        for (int c = 0; c < 20 && !out_valid; c++) @(negedge clk);
        @(posedge clk);
        #1;
        addr_clr = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check_val("clr_hs_addr", out_addr, BASE + 32'h4);
        @(posedge clk);
        #1;
        addr_clr = 1'b0;
        @(negedge clk);
        check_val("clr_next_addr", out_addr, BASE);
        check_val("clr_next_instr", out_instr, 32'h0C80_0593);
        @(posedge clk);
        #1;
        drain();

        // asynchronous reset with both stages full
        out_ready = 1'b0;
        send_m(3'd1, 7'h13, 5'd20, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
        send_m(3'd1, 7'h13, 5'd21, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9);
        #2;
        check_val("pre_rst_valid", 32'(out_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        check_val("rst_async_valid", 32'(out_valid), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCD_E000, 32'hABCD_E2B7, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check_val("post_rst_addr", out_addr, BASE);
        drain();
        repeat (3) @(negedge clk);
        check_val("final_idle", 32'(out_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
